// File: rtl/nlm_read_aligner.sv
// nlm_read_aligner: aligns SRAM read data to its strobe, tags raster position, buffers in a FIFO.
// Define NLM_RDAL_BAYER_EN to add the registered cfa_o Bayer-phase output.
module nlm_read_aligner #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 4032,
  parameter int IMAGE_HEIGHT = 3024,
  parameter int CNT_WIDTH    = 12,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  rden_i,
  input  logic [DATA_WIDTH-1:0] rddata_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] pix_o,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic [CNT_WIDTH-1:0]  x_o,
  output logic [CNT_WIDTH-1:0]  y_o,
  output logic                  sol_o,
  output logic                  eol_o,
  output logic                  sof_o,
  output logic                  eof_o,
`ifdef NLM_RDAL_BAYER_EN
  output logic [1:0]            cfa_o,
`endif
  output logic                  err_o
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int SW  = AW + 2;
`ifdef NLM_RDAL_BAYER_EN
  localparam int EW = DATA_WIDTH + 2 * CNT_WIDTH + 6;
`else
  localparam int EW = DATA_WIDTH + 2 * CNT_WIDTH + 4;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]    x_q, x_d, y_q, y_d;
  logic                    err_q, err_d;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [EW-1:0]           mem_d [FIFO_DEPTH];

  logic          push, pop, full, wr_en, abort;
  logic          last_x, last_y;
  logic [EW-1:0] ent;
  logic [SW-1:0] infl;

  always_comb begin
    last_x = x_q == CNT_WIDTH'(IMAGE_WIDTH - 1);
    last_y = y_q == CNT_WIDTH'(IMAGE_HEIGHT - 1);
`ifdef NLM_RDAL_BAYER_EN
    ent = {y_q[0], x_q[0], last_x && last_y, x_q == '0 && y_q == '0,
           last_x, x_q == '0, y_q, x_q, rddata_i};
`else
    ent = {last_x && last_y, x_q == '0 && y_q == '0,
           last_x, x_q == '0, y_q, x_q, rddata_i};
`endif
    full  = cnt_q == AW1'(FIFO_DEPTH);
    pop   = cnt_q != '0 && pix_ready_i;
    push  = state_q == RUN && vld_q[READ_LATENCY-1];
    wr_en = push && (!full || pop);
    abort = state_q != IDLE && !en_i;
    infl  = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      infl = infl + SW'(vld_q[i]);
    end

    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    mem_d   = mem_q;
    vld_d   = '0;
    vld_d[0] = state_q == RUN && rden_i;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    if (pop) rd_d = rd_q + 1'b1;
    if (wr_en) begin
      mem_d[wr_q] = ent;
      wr_d = wr_q + 1'b1;
    end
    if (push && !wr_en) err_d = 1'b1;
    if (wr_en && !pop) cnt_d = cnt_q + 1'b1;
    else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;

    unique case (state_q)
      IDLE: begin
        vld_d = '0;
        if (en_i) state_d = RUN;
      end
      RUN: begin
        // dropped pushes still advance the raster position
        if (push) begin
          if (last_x) begin
            x_d = '0;
            if (last_y) begin
              y_d = '0;
              state_d = DRAIN;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = en_i ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      vld_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      x_d     = '0;
      y_d     = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vld_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign pix_valid_o = cnt_q != '0;
  assign stall_o     = ({1'b0, cnt_q} + infl) >= SW'(FIFO_DEPTH);
  assign err_o       = err_q;
`ifdef NLM_RDAL_BAYER_EN
  assign {cfa_o, eof_o, sof_o, eol_o, sol_o, y_o, x_o, pix_o} = mem_q[rd_q];
`else
  assign {eof_o, sof_o, eol_o, sol_o, y_o, x_o, pix_o} = mem_q[rd_q];
`endif

endmodule
